playfield_hscroll_multi: RTL
============================

// Module: playfield_hscroll_multi
// PURPOSE
//  Generalised horizontal-scroll engine for N playfield layers.
//  - Per layer: double-buffered scroll register, fine/coarse pixel counters and tile-column address.
//  - Per layer: tile-row fetch request and prefetched pixel serializer.
//  - Per layer: per-colour priority lookup producing a "playfield over motion object" flag.
//  - Sits between the CPU/VBD bus write decode and the playfield ROM/colour-mux path.
//  - Successor to the fixed single-layer 9-bit scroll logic.
// PARAMETERS
//  NUM_LAYERS  2  independent playfield layers (1..4)
//  XW          9  scroll value width in pixels; coarse width = XW-FINE_W
//  FINE_W      3  log2 tile width in pixels (tile = 8 px)
//  PIX_W       4  bits per pixel colour index
//  PRIO_W      8  priority mask bits per layer, indexed by pix[$clog2(PRIO_W)-1:0]
// PORTS
//  clk            in   1                      system clock, all logic posedge
//  rst_b          in   1                      async reset, active low
//  pix_en         in   1                      pixel-rate clock enable
//  line_start     in   1                      one-cycle pulse (qualified by pix_en), horizontal start
//  scroll_we      in   1                      scroll write strobe
//  scroll_sel     in   $clog2(NUM_LAYERS)     target layer of scroll/prio write
//  scroll_data    in   XW                     scroll value
//  prio_we        in   1                      priority mask write strobe
//  prio_data      in   PRIO_W                 priority mask
//  fetch_req      out  NUM_LAYERS             level, high while a row fetch is outstanding
//  fetch_col      out  NUM_LAYERS*(XW-FINE_W) tile column to fetch, per layer
//  fetch_ack      in   NUM_LAYERS             one-cycle, row data valid
//  fetch_row      in   NUM_LAYERS*(PIX_W<<FINE_W)  row pixels, pixel 0 in LSBs
//  pix_out        out  NUM_LAYERS*PIX_W       current pixel per layer
//  pf_over_mo     out  NUM_LAYERS             prio_mask[pix_out] per layer
//  underrun       out  NUM_LAYERS             sticky; row missed at tile boundary
// BEHAVIOUR
//  - Reset (async, rst_b=0): every register and output is 0; fetch_req=0, underrun=0.
//  - Writes: scroll_we/prio_we load pending regs of scroll_sel on any clk (no pix_en needed).
//    - Pending scroll copies to active only on line_start&pix_en.
//    - Write coincident with line_start: new value is active for that line (write-through).
//    - prio mask takes effect the cycle after write (not line-synchronised).
//  - line_start&pix_en, per layer:
//    - fine <= active[FINE_W-1:0]; coarse <= active[XW-1:FINE_W].
//    - Shift buffer and prefetch buffer cleared.
//    - fetch_req=1 with fetch_col=coarse; the second fetch follows with coarse+1.
//    - No pixels emitted until the first row is loaded; pix_out=0 meanwhile.
//  - Counters (pix_en only):
//    - fine increments by 1.
//    - At fine wrap (all ones -> 0), coarse increments modulo 2^(XW-FINE_W).
//    - Column wrap-around is silent.
//  - Fetch handshake:
//    - fetch_req rises when the prefetch slot is empty; fetch_col is stable while req=1.
//    - fetch_ack with req=1 fills prefetch and drops req next cycle.
//    - fetch_ack without req is ignored.
//  - Tile boundary (fine wrap & pix_en):
//    - Prefetch moves to shift buffer and prefetch empties; new req issued for coarse+1.
//    - Prefetch empty at boundary: shift buffer loads zeros and underrun sets (cleared only by reset).
//    - ack on the boundary cycle: data goes straight to shift buffer; no underrun.
//  - Serializer: pix_out = shift_buf[fine] registered on pix_en; 1 clk latency from pix_en.
//    - First line pixel = row pixel at index scroll[FINE_W-1:0].
//  - pf_over_mo: combinational from registered pix_out and prio mask (no added latency).
//  - rst_b asserted mid-line: immediate clear; after release, output stays idle until next line_start.
// STRUCTURE
//  - Package pf_hscroll_pkg:
//    - Constants: default XW/FINE_W/PIX_W.
//    - typedef lane_state_t {IDLE, FILL, RUN}.
//    - Function col_next() for modulo column increment.
//  - Sub-module playfield_hscroll_lane: one layer (regs, counters, fetch FSM, serializer, prio).
//    - Instantiated NUM_LAYERS times by generate.
//    - Top holds only write decode and port flattening.
//  - Lane FSM:
//    - IDLE -> FILL on line_start.
//    - FILL -> RUN when first row is loaded.
//    - RUN -> FILL on line_start.
//    - Any state -> IDLE on reset.
// TESTING
//  - Reset: rst_b=0 mid-line -> all outputs 0 same cycle; next line_start required before pixels.
//  - Scroll 0x00B on layer 1, ack each req in 2 clks:
//    - fetch_col 1 then 2.
//    - First pix_out = row(col1)[3].
//    - Col 2 pixel 0 after 5 pixels.
//  - Scroll 0x1FF:
//    - First fetch_col=63, next 0 (wrap).
//    - Pixel 7 of col 63, then col 0 pixel 0.
//  - Withhold fetch_ack past boundary -> underrun[0]=1, 8 zero pixels, layer 1 unaffected.
//  - Write 0x020 during line -> no change until line_start; write on line_start cycle -> applied that line.
//  - prio_data=8'h81, pix values 0,7,3 -> pf_over_mo 1,1,0.

Source files
------------

// File: rtl/pf_hscroll_pkg.sv
// pf_hscroll_pkg: shared constants, lane state type and column arithmetic for the playfield scroller
package pf_hscroll_pkg;

  localparam int XW_DEF     = 9;
  localparam int FINE_W_DEF = 3;
  localparam int PIX_W_DEF  = 4;
  localparam int PRIO_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, FILL, RUN} lane_state_t;

  function automatic logic [15:0] col_next(input logic [15:0] col, input int cw);
    return (col + 16'd1) & ((16'd1 << cw) - 16'd1);
  endfunction

endpackage

// File: rtl/playfield_hscroll_lane.sv
// playfield_hscroll_lane: one layer's scroll counters, row fetch, pixel serializer and priority flag
module playfield_hscroll_lane
  import pf_hscroll_pkg::*;
#(
  parameter int XW     = XW_DEF,
  parameter int FINE_W = FINE_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int PRIO_W = PRIO_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        pix_en,
  input  logic                        line_start,
  input  logic                        scroll_we,
  input  logic [XW-1:0]               scroll_data,
  input  logic                        prio_we,
  input  logic [PRIO_W-1:0]           prio_data,
  output logic                        fetch_req,
  output logic [XW-FINE_W-1:0]        fetch_col,
  input  logic                        fetch_ack,
  input  logic [(PIX_W<<FINE_W)-1:0]  fetch_row,
  output logic [PIX_W-1:0]            pix_out,
  output logic                        pf_over_mo,
  output logic                        underrun
);

  localparam int CW = XW - FINE_W;
  localparam int IW = $clog2(PRIO_W);

  lane_state_t state, state_nx;
  logic [XW-1:0]              pend, eff;
  logic [FINE_W-1:0]          fine;
  logic [CW-1:0]              coarse, c1, c2;
  logic [(PIX_W<<FINE_W)-1:0] shift_buf, pre_buf;
  logic [PRIO_W-1:0]          prio_mask;
  logic                       pre_full, start, run_pix, bound, take;

  assign start      = line_start & pix_en;
  assign eff        = scroll_we ? scroll_data : pend;
  assign run_pix    = pix_en & (state == RUN);
  assign bound      = run_pix & (&fine);
  assign take       = fetch_ack & fetch_req;
  assign c1         = CW'(col_next(16'(coarse), CW));
  assign c2         = CW'(col_next(16'(c1), CW));
  assign pf_over_mo = prio_mask[pix_out[IW-1:0]];

  // lane state register
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= IDLE;
    else state <= state_nx;

  // lane next state: a new line always refills, the first loaded row starts output
  always_comb begin
    state_nx = state;
    if (start) state_nx = FILL;
    else if (state == FILL && take) state_nx = RUN;
  end

  // scroll/prio registers, counters, fetch handshake and serializer
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pend      <= '0;
      prio_mask <= '0;
      fine      <= '0;
      coarse    <= '0;
      shift_buf <= '0;
      pre_buf   <= '0;
      pre_full  <= 1'b0;
      fetch_req <= 1'b0;
      fetch_col <= '0;
      pix_out   <= '0;
      underrun  <= 1'b0;
    end else begin
      if (scroll_we) pend <= scroll_data;
      if (prio_we) prio_mask <= prio_data;
      if (start) begin
        fine      <= eff[FINE_W-1:0];
        coarse    <= eff[XW-1:FINE_W];
        shift_buf <= '0;
        pre_buf   <= '0;
        pre_full  <= 1'b0;
        fetch_req <= 1'b1;
        fetch_col <= eff[XW-1:FINE_W];
        pix_out   <= '0;
      end else begin
        if (run_pix) begin
          fine    <= fine + 1'b1;
          pix_out <= shift_buf[PIX_W*fine +: PIX_W];
        end
        if (bound) begin
          coarse    <= c1;
          shift_buf <= pre_full ? pre_buf : take ? fetch_row : '0;
          pre_full  <= 1'b0;
          if (!pre_full && !take) underrun <= 1'b1;
          fetch_req <= 1'b1;
          fetch_col <= c2;
        end else if (take) begin
          if (state == FILL) begin
            shift_buf <= fetch_row;
            fetch_col <= c1;
          end else begin
            pre_buf  <= fetch_row;
            pre_full <= 1'b1;
          end
          fetch_req <= 1'b0;
        end else if (state == RUN && !pre_full && !fetch_req) fetch_req <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/playfield_hscroll_multi.sv
// playfield_hscroll_multi: N-layer horizontal scroll engine, write decode and port flattening
module playfield_hscroll_multi
  import pf_hscroll_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int XW         = XW_DEF,
  parameter int FINE_W     = FINE_W_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int PRIO_W     = PRIO_W_DEF,
  localparam int SEL_W     = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1,
  localparam int CW        = XW - FINE_W,
  localparam int ROW_W     = PIX_W << FINE_W
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        pix_en,
  input  logic                        line_start,
  input  logic                        scroll_we,
  input  logic [SEL_W-1:0]            scroll_sel,
  input  logic [XW-1:0]               scroll_data,
  input  logic                        prio_we,
  input  logic [PRIO_W-1:0]           prio_data,
  output logic [NUM_LAYERS-1:0]       fetch_req,
  output logic [NUM_LAYERS*CW-1:0]    fetch_col,
  input  logic [NUM_LAYERS-1:0]       fetch_ack,
  input  logic [NUM_LAYERS*ROW_W-1:0] fetch_row,
  output logic [NUM_LAYERS*PIX_W-1:0] pix_out,
  output logic [NUM_LAYERS-1:0]       pf_over_mo,
  output logic [NUM_LAYERS-1:0]       underrun
);

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
    logic sel;
    assign sel = scroll_sel == SEL_W'(g);
    playfield_hscroll_lane #(
      .XW(XW), .FINE_W(FINE_W), .PIX_W(PIX_W), .PRIO_W(PRIO_W)
    ) u_lane (
      .clk(clk),
      .rst_b(rst_b),
      .pix_en(pix_en),
      .line_start(line_start),
      .scroll_we(scroll_we & sel),
      .scroll_data(scroll_data),
      .prio_we(prio_we & sel),
      .prio_data(prio_data),
      .fetch_req(fetch_req[g]),
      .fetch_col(fetch_col[g*CW +: CW]),
      .fetch_ack(fetch_ack[g]),
      .fetch_row(fetch_row[g*ROW_W +: ROW_W]),
      .pix_out(pix_out[g*PIX_W +: PIX_W]),
      .pf_over_mo(pf_over_mo[g]),
      .underrun(underrun[g])
    );
  end

endmodule
